wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the register file's single write port (WE3/AD3/WD3) between two writeback requesters: the ALU result path and the load/memory result path.
- Grants at most one write per cycle and registers the winning write onto the port.
- Keeps a pending-write scoreboard per architectural register; issue logic consults it to stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- ADDRESS_WIDTH, 5, register address width; 2**ADDRESS_WIDTH registers.
- DATA_WIDTH, 32, register data width.
- MAX_WAIT, 3, consecutive lost cycles before the ALU requester is promoted over memory (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDRESS_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- mem_valid  in  1  load writeback request.
- mem_rd  in  ADDRESS_WIDTH  load destination register.
- mem_data  in  DATA_WIDTH  load data.
- mem_ready  out  1  load request accepted this cycle (combinational).
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_rd  in  ADDRESS_WIDTH  destination of the issuing instruction.
- chk_ad1, chk_ad2  in  ADDRESS_WIDTH  source registers of the instruction in decode.
- hazard  out  1  pending[chk_ad1] | pending[chk_ad2] (combinational).
- waw_block  out  1  pending[iss_rd] (combinational); issuer must not assert iss_valid while this is 1.
- WE3  out  1  register file write enable (registered).
- AD3  out  ADDRESS_WIDTH  register file write address (registered).
- WD3  out  DATA_WIDTH  register file write data (registered).

Behaviour:
- Reset (async assert, sync release): WE3=0, AD3=0, WD3=0, all pending bits 0, wait counter 0. Any in-flight grant is discarded.
- Transfer occurs when valid & ready in the same cycle. Requester holds valid, rd and data stable until accepted.
- Readiness: ready may depend on valid. Ready is 0 whenever that requester's valid is 0.
- Arbitration, per cycle:
  - Only one requester valid: it is granted.
  - Both valid: mem wins, unless wait_cnt == MAX_WAIT, in which case alu wins.
- Wait counter: +1 on each cycle alu_valid=1 and alu is not granted, saturating at MAX_WAIT. Cleared when alu is granted or alu_valid=0.
- Output stage:
  - Grant in cycle N: WE3=1, AD3=rd, WD3=data during cycle N+1. The register file commits at the end of N+1. Latency is 1 cycle.
  - No grant in cycle N: WE3=0 in cycle N+1; AD3/WD3 hold their previous values.
- Register x0: a granted request with rd==0 is accepted (ready=1) but WE3 stays 0 in N+1. Pending bit 0 is never set.
- Scoreboard set: on iss_valid=1 with iss_rd!=0, pending[iss_rd] is set at the clock edge.
- Scoreboard clear: in any cycle WE3=1, pending[AD3] is cleared at that cycle's closing edge, concurrent with the register file write. hazard therefore stays 1 through the write cycle and drops the cycle after.
- Simultaneous set and clear of the same register at one edge: set wins.
- Simultaneous set and clear of different registers: both take effect.
- A write to a register whose pending bit is 0 is legal; the clear is a no-op.
- The arbiter imposes no back-pressure beyond losing arbitration. Throughput is one write per cycle.

Test Plan:
- Single ALU write: alu_valid=1, rd=5, data=0xDEADBEEF in cycle 0 -> alu_ready=1 in cycle 0; WE3=1, AD3=5, WD3=0xDEADBEEF in cycle 1; WE3=0 in cycle 2.
- Contention and starvation, MAX_WAIT=3: both valid continuously, mem presents new rd each cycle -> mem granted cycles 0-2, alu granted cycle 3, mem granted cycle 4; after alu drops, wait_cnt returns to 0.
- x0 suppression: mem_valid=1, rd=0, data=0x1234 -> mem_ready=1; WE3 stays 0 next cycle; pending vector unchanged.
- Hazard lifecycle: iss rd=10 at cycle 0 -> chk_ad1=10 gives hazard=1 from cycle 1. ALU grant for rd=10 at cycle 4 -> WE3=1 in cycle 5 with hazard still 1; hazard=0 in cycle 6. waw_block=1 for iss_rd=10 over cycles 1-5.
- Set/clear collision: WE3=1, AD3=7 in the same cycle as iss_valid=1, iss_rd=7 -> pending[7]=1 afterwards.
- Reset mid-operation: grant issued, rst_n pulled low before the next edge -> WE3=0 immediately; all pending bits 0; after release, no stale write appears.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the ALU and load writeback paths,
// with a per-register pending-write scoreboard for RAW/WAW stalls in issue.
module wb_port_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_WAIT      = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    output logic                     mem_ready,
    input  logic                     iss_valid,
    input  logic [ADDRESS_WIDTH-1:0] iss_rd,
    input  logic [ADDRESS_WIDTH-1:0] chk_ad1,
    input  logic [ADDRESS_WIDTH-1:0] chk_ad2,
    output logic                     hazard,
    output logic                     waw_block,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]    WD3
);
    // Handshake: a transfer happens when valid & ready in the same cycle;
    // ready is combinational, never asserted without its valid, and the
    // requester holds valid/rd/data stable until it is accepted.
    localparam int         NREGS       = 2 ** ADDRESS_WIDTH;
    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]               r_wait_cnt;
    logic [NREGS-1:0]         r_pending;
    logic                     w_alu_grant;
    logic                     w_mem_grant;
    logic                     w_write;
    logic [ADDRESS_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0]    w_data;
    logic [3:0]               w_wait_nxt;
    logic [NREGS-1:0]         w_pending_nxt;

    // Memory normally wins; the ALU is promoted once it has lost MAX_WAIT times in a row.
    assign w_alu_grant = alu_valid & (~mem_valid | (r_wait_cnt == LP_MAX_WAIT));
    assign w_mem_grant = mem_valid & ~w_alu_grant;
    assign alu_ready   = w_alu_grant;
    assign mem_ready   = w_mem_grant;

    assign w_rd    = w_alu_grant ? alu_rd : mem_rd;
    assign w_data  = w_alu_grant ? alu_data : mem_data;
    assign w_write = (w_alu_grant | w_mem_grant) & (w_rd != '0);

    assign hazard    = r_pending[chk_ad1] | r_pending[chk_ad2];
    assign waw_block = r_pending[iss_rd];

    always_comb begin
        w_wait_nxt = '0;
        if (alu_valid && !w_alu_grant) begin
            w_wait_nxt = (r_wait_cnt == LP_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 4'd1;
        end
    end

    // Clear from the write in flight first so a same-edge issue to that register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (WE3) begin
            w_pending_nxt[AD3] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            w_pending_nxt[iss_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_pending  <= '0;
            WE3        <= 1'b0;
            AD3        <= '0;
            WD3        <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            r_pending  <= w_pending_nxt;
            WE3        <= w_write;
            if (w_write) begin
                AD3 <= w_rd;
                WD3 <= w_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed table, hand sequences and random traffic
// checked against a rule-level model of arbitration, writes and scoreboard.
module tb_wb_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MW = 3;
    localparam int NR = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid, mem_valid, iss_valid;
    logic [AW-1:0] alu_rd, mem_rd, iss_rd, chk_ad1, chk_ad2;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready, hazard, waw_block, WE3;
    logic [AW-1:0] AD3;
    logic [DW-1:0] WD3;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit            m_pend[NR];
    int            m_wait;
    bit            m_we;
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_wd;
    bit            g_alu, g_mem;

    typedef struct {
        bit            av;
        logic [AW-1:0] ard;
        bit            mv;
        logic [AW-1:0] mrd;
        bit            exp_ar;
        bit            exp_mr;
    } vec_t;
    vec_t vecs[12];

    wb_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_ad1(chk_ad1), .chk_ad2(chk_ad2),
        .hazard(hazard), .waw_block(waw_block), .WE3(WE3), .AD3(AD3), .WD3(WD3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        iss_valid = 0; iss_rd = '0; chk_ad1 = '0; chk_ad2 = '0;
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_wait = 0;
        m_we   = 0;
    endtask

    function automatic void model_grant();
        g_alu = alu_valid && (!mem_valid || m_wait == MW);
        g_mem = mem_valid && !g_alu;
    endfunction

    // Compare every output with the model, 1 time unit after the inputs change.
    task automatic check_cycle();
        #1;
        model_grant();
        chk("alu_ready", alu_ready, g_alu);
        chk("mem_ready", mem_ready, g_mem);
        chk("hazard", hazard, m_pend[chk_ad1] | m_pend[chk_ad2]);
        chk("waw_block", waw_block, m_pend[iss_rd]);
        chk("WE3", WE3, m_we);
        if (m_we) begin
            chk("AD3", AD3, m_ad);
            chk("WD3", WD3, m_wd);
        end
    endtask

    task automatic tick();
        model_grant();
        @(posedge clk);
        if (m_we) m_pend[m_ad] = 0;
        if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1;
        m_wait = (alu_valid && !g_alu) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
        if (g_alu && alu_rd != 0) begin
            m_we = 1; m_ad = alu_rd; m_wd = alu_data;
        end else if (g_mem && mem_rd != 0) begin
            m_we = 1; m_ad = mem_rd; m_wd = mem_data;
        end else begin
            m_we = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        idle();
        do_reset();
        check_cycle();
        chk("reset WE3", WE3, 0);
        chk("reset AD3", AD3, 0);
        chk("reset WD3", WD3, 0);
        chk("reset hazard", hazard, 0);

        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        check_cycle();
        chk("single alu_ready", alu_ready, 1);
        tick();
        idle();
        check_cycle();
        chk("single WE3", WE3, 1);
        chk("single AD3", AD3, 5);
        chk("single WD3", WD3, 32'hDEADBEEF);
        tick();
        check_cycle();
        chk("single WE3 off", WE3, 0);

        // x0 write is accepted but never reaches the port
        mem_valid = 1; mem_rd = 0; mem_data = 32'h1234;
        check_cycle();
        chk("x0 mem_ready", mem_ready, 1);
        tick();
        idle();
        check_cycle();
        chk("x0 WE3", WE3, 0);
        chk("x0 hazard", hazard, 0);
        tick();

        // Hazard lifecycle on r10
        iss_valid = 1; iss_rd = 10;
        check_cycle();
        tick();
        iss_valid = 0; chk_ad1 = 10;
        for (int c = 1; c <= 3; c++) begin
            check_cycle();
            chk("life hazard", hazard, 1);
            chk("life waw", waw_block, 1);
            tick();
        end
        alu_valid = 1; alu_rd = 10; alu_data = 32'hCAFE0010;
        check_cycle();
        chk("life hazard c4", hazard, 1);
        chk("life alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        check_cycle();
        chk("life WE3 c5", WE3, 1);
        chk("life AD3 c5", AD3, 10);
        chk("life hazard c5", hazard, 1);
        chk("life waw c5", waw_block, 1);
        tick();
        check_cycle();
        chk("life hazard c6", hazard, 0);
        chk("life waw c6", waw_block, 0);
        tick();

        // Set/clear collision on r7
        idle();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        check_cycle();
        tick();
        alu_valid = 0; iss_valid = 1; iss_rd = 7;
        check_cycle();
        chk("coll WE3", WE3, 1);
        chk("coll AD3", AD3, 7);
        tick();
        iss_valid = 0; chk_ad2 = 7;
        check_cycle();
        chk("coll pending7", hazard, 1);
        tick();
        idle();
        check_cycle();
        tick();

        // Contention / starvation table, starting with the wait count at 0
        vecs[0]  = '{1, 1,  1, 2, 0, 1};
        vecs[1]  = '{1, 1,  1, 3, 0, 1};
        vecs[2]  = '{1, 1,  1, 4, 0, 1};
        vecs[3]  = '{1, 1,  1, 4, 1, 0};
        vecs[4]  = '{0, 0,  1, 5, 0, 1};
        vecs[5]  = '{1, 12, 1, 6, 0, 1};
        vecs[6]  = '{1, 12, 1, 7, 0, 1};
        vecs[7]  = '{1, 12, 1, 8, 0, 1};
        vecs[8]  = '{1, 12, 1, 9, 1, 0};
        vecs[9]  = '{1, 16, 0, 9, 1, 0};
        vecs[10] = '{0, 0,  0, 0, 0, 0};
        vecs[11] = '{0, 0,  1, 0, 0, 1};
        foreach (vecs[i]) begin
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = 32'hA0000000 | 32'(vecs[i].ard);
            mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = 32'hB0000000 | 32'(vecs[i].mrd);
            check_cycle();
            chk($sformatf("vec%0d alu_ready", i), alu_ready, vecs[i].exp_ar);
            chk($sformatf("vec%0d mem_ready", i), mem_ready, vecs[i].exp_mr);
            tick();
        end
        idle();
        check_cycle();
        tick();

        // Reset in the middle of a write
        iss_valid = 1; iss_rd = 4;
        check_cycle();
        tick();
        iss_valid = 0; chk_ad1 = 4;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h55;
        check_cycle();
        chk("rst pre hazard", hazard, 1);
        tick();
        alu_valid = 0;
        check_cycle();
        chk("rst pre WE3", WE3, 1);
        rst_n = 0;
        #1;
        chk("rst async WE3", WE3, 0);
        chk("rst async hazard", hazard, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        check_cycle();
        chk("rst post WE3", WE3, 0);
        tick();
        check_cycle();
        chk("rst post WE3 2", WE3, 0);
        tick();

        // Random traffic against the model
        idle();
        for (int c = 0; c < 3000; c++) begin
            chk_ad1   = AW'($urandom_range(0, 7));
            chk_ad2   = AW'($urandom_range(0, 7));
            iss_rd    = AW'($urandom_range(0, 7));
            iss_valid = ($urandom_range(0, 3) == 0) && !m_pend[iss_rd];
            check_cycle();
            tick();
            if (!alu_valid || g_alu) begin
                alu_valid = $urandom_range(0, 99) < 55;
                alu_rd    = AW'($urandom_range(0, 7));
                alu_data  = $urandom();
            end
            if (!mem_valid || g_mem) begin
                mem_valid = $urandom_range(0, 99) < 55;
                mem_rd    = AW'($urandom_range(0, 7));
                mem_data  = $urandom();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
